// File: rtl/branch_flag_stage_if.sv
// ---------------------------------------------------------------------------
// branch_flag_stage_if
//
// Purpose: bundles the EX-side inputs and the MEM-side outputs of the
// execute-to-memory boundary stage into one connection.
//
// Signal summary:
//   in_valid               EX holds a live instruction
//   stall, flush           pipeline control (flush beats stall)
//   alu_result             ALU output (WIDTH bits)
//   alu_zero/neg/carry/ovf ALU Z, N, C, V
//   set_flags              instruction is ADDS/SUBS/ANDS
//   is_b/is_cbz/is_cbnz/is_bcond  branch kind (at most one set)
//   cond                   B.cond condition code
//   br_target              computed branch target (WIDTH bits)
//   out_valid/out_result   registered valid and result to MEM
//   flags                  architectural {N,Z,C,V}
//   br_taken/br_pc         registered branch decision and target
//
// Modports:
//   master - the EX side, which drives the instruction and sees the results
//   slave  - the stage itself
// ---------------------------------------------------------------------------
interface branch_flag_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_carry;
    logic             alu_ovf;
    logic             set_flags;
    logic             is_b;
    logic             is_cbz;
    logic             is_cbnz;
    logic             is_bcond;
    logic [3:0]       cond;
    logic [WIDTH-1:0] br_target;

    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       flags;
    logic             br_taken;
    logic [WIDTH-1:0] br_pc;

    modport master (
        output in_valid, stall, flush, alu_result, alu_zero, alu_neg,
               alu_carry, alu_ovf, set_flags, is_b, is_cbz, is_cbnz,
               is_bcond, cond, br_target,
        input  out_valid, out_result, flags, br_taken, br_pc
    );

    modport slave (
        input  in_valid, stall, flush, alu_result, alu_zero, alu_neg,
               alu_carry, alu_ovf, set_flags, is_b, is_cbz, is_cbnz,
               is_bcond, cond, br_target,
        output out_valid, out_result, flags, br_taken, br_pc
    );
endinterface

// File: rtl/branch_flag_stage.sv
// ---------------------------------------------------------------------------
// branch_flag_stage
//
// Purpose: execute-to-memory boundary of the 64-bit pipelined CPU. Holds the
// architectural NZCV flag register, resolves B / CBZ / CBNZ / B.cond and
// registers the ALU result, the branch decision and the branch target for the
// memory stage, honouring stall and flush.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - asynchronous, active-low; 0 clears all state immediately
//   bus    - branch_flag_stage_if.slave carrying EX inputs and MEM outputs
// ---------------------------------------------------------------------------
module branch_flag_stage #(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_flag_stage_if.slave     bus
);

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_taken;
    logic [WIDTH-1:0] r_pc;

    logic             w_condMet;
    logic             w_decision;
    logic             w_flagWrite;

    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    // B.cond looks at the flags already committed, never at this cycle's ALU
    // flags: a flag setter and a B.cond are never the same instruction.
    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition-code evaluation; codes E and F mean "always".
    always_comb begin
        w_condMet = 1'b1;
        case (bus.cond)
            4'h0:    w_condMet = w_z;
            4'h1:    w_condMet = ~w_z;
            4'h2:    w_condMet = w_c;
            4'h3:    w_condMet = ~w_c;
            4'h4:    w_condMet = w_n;
            4'h5:    w_condMet = ~w_n;
            4'h6:    w_condMet = w_v;
            4'h7:    w_condMet = ~w_v;
            4'h8:    w_condMet = w_c & ~w_z;
            4'h9:    w_condMet = ~w_c | w_z;
            4'hA:    w_condMet = (w_n == w_v);
            4'hB:    w_condMet = (w_n != w_v);
            4'hC:    w_condMet = ~w_z & (w_n == w_v);
            4'hD:    w_condMet = w_z | (w_n != w_v);
            default: w_condMet = 1'b1;
        endcase
    end

    // Branch decision by kind; at most one kind is set, so the priority order
    // here never actually arbitrates anything.
    always_comb begin
        w_decision = 1'b0;
        if (bus.is_b) begin
            w_decision = 1'b1;
        end else if (bus.is_cbz) begin
            w_decision = bus.alu_zero;
        end else if (bus.is_cbnz) begin
            w_decision = ~bus.alu_zero;
        end else if (bus.is_bcond) begin
            w_decision = w_condMet;
        end
    end

    assign w_flagWrite = bus.in_valid & bus.set_flags & ~bus.stall & ~bus.flush;

    // Architectural flag register: only a live, unstalled, unflushed flag
    // setter may change it; a later setter simply overwrites an earlier one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_flagWrite) begin
            r_flags <= {bus.alu_neg, bus.alu_zero, bus.alu_carry, bus.alu_ovf};
        end
    end

    // Pipeline register toward MEM. Flush kills the slot but leaves result and
    // target alone since they are meaningless without out_valid. Flush is
    // checked first so that it beats a simultaneous stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_taken  <= 1'b0;
            r_pc     <= '0;
        end else if (bus.flush) begin
            r_valid  <= 1'b0;
            r_taken  <= 1'b0;
        end else if (!bus.stall) begin
            r_valid  <= bus.in_valid;
            r_result <= bus.alu_result;
            r_pc     <= bus.br_target;
            r_taken  <= bus.in_valid & w_decision;
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.flags      = r_flags;
    assign bus.br_taken   = r_taken;
    assign bus.br_pc      = r_pc;

endmodule

// File: tb/tb_branch_flag_stage.sv
// ---------------------------------------------------------------------------
// tb_branch_flag_stage
//
// Purpose: directed self-checking bench for branch_flag_stage. Inputs change
// one time unit after a rising edge; outputs are sampled one time unit after
// the following rising edge.
// ---------------------------------------------------------------------------
module tb_branch_flag_stage;

    localparam int WIDTH = 64;

    logic clk;
    logic reset;

    int checkCount = 0;
    int failCount  = 0;

    branch_flag_stage_if #(.WIDTH(WIDTH)) bus ();

    branch_flag_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one full set of EX inputs. nzcv = {neg, zero, carry, ovf};
    // kind = {is_b, is_cbz, is_cbnz, is_bcond}.
    task automatic applyStimulus(
        input logic             valid,
        input logic             stall,
        input logic             flush,
        input logic [WIDTH-1:0] result,
        input logic [3:0]       nzcv,
        input logic             setFlags,
        input logic [3:0]       kind,
        input logic [3:0]       cond,
        input logic [WIDTH-1:0] target
    );
        bus.in_valid   = valid;
        bus.stall      = stall;
        bus.flush      = flush;
        bus.alu_result = result;
        bus.alu_neg    = nzcv[3];
        bus.alu_zero   = nzcv[2];
        bus.alu_carry  = nzcv[1];
        bus.alu_ovf    = nzcv[0];
        bus.set_flags  = setFlags;
        bus.is_b       = kind[3];
        bus.is_cbz     = kind[2];
        bus.is_cbnz    = kind[1];
        bus.is_bcond   = kind[0];
        bus.cond       = cond;
        bus.br_target  = target;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(
        input string            tag,
        input logic [WIDTH-1:0] observed,
        input logic [WIDTH-1:0] expected
    );
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_B     = 4'b1000;
    localparam logic [3:0] K_CBZ   = 4'b0100;
    localparam logic [3:0] K_CBNZ  = 4'b0010;
    localparam logic [3:0] K_BCOND = 4'b0001;

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 64'h0, 4'b0000, 0, K_NONE, 4'h0, 64'h0);
        #3;

        // Reset values
        checkOutput("rst_valid",  {63'b0, bus.out_valid}, 64'h0);
        checkOutput("rst_result", bus.out_result,         64'h0);
        checkOutput("rst_flags",  {60'b0, bus.flags},     64'h0);
        checkOutput("rst_taken",  {63'b0, bus.br_taken},  64'h0);
        checkOutput("rst_pc",     bus.br_pc,              64'h0);

        @(negedge clk);
        reset = 1'b1;
        stepClock();

        // CBZ with a zero result is taken
        applyStimulus(1, 0, 0, 64'h0, 4'b0100, 0, K_CBZ, 4'h0, 64'h40);
        stepClock();
        checkOutput("cbz_valid", {63'b0, bus.out_valid}, 64'h1);
        checkOutput("cbz_taken", {63'b0, bus.br_taken},  64'h1);
        checkOutput("cbz_pc",    bus.br_pc,              64'h40);
        checkOutput("cbz_result", bus.out_result,        64'h0);

        // CBNZ with a zero result is not taken
        applyStimulus(1, 0, 0, 64'h0, 4'b0100, 0, K_CBNZ, 4'h0, 64'h40);
        stepClock();
        checkOutput("cbnz0_taken", {63'b0, bus.br_taken}, 64'h0);

        // CBNZ with a nonzero result is taken
        applyStimulus(1, 0, 0, 64'h1, 4'b0000, 0, K_CBNZ, 4'h0, 64'h80);
        stepClock();
        checkOutput("cbnz1_taken",  {63'b0, bus.br_taken}, 64'h1);
        checkOutput("cbnz1_result", bus.out_result,        64'h1);
        checkOutput("cbnz1_pc",     bus.br_pc,             64'h80);

        // SUBS N=1 Z=0 C=0 V=0
        applyStimulus(1, 0, 0, 64'h8000_0000_0000_0000, 4'b1000, 1, K_NONE, 4'h0, 64'h0);
        stepClock();
        checkOutput("subs_flags", {60'b0, bus.flags},    64'h8);
        checkOutput("subs_taken", {63'b0, bus.br_taken}, 64'h0);

        // B.LT sees N!=V
        applyStimulus(1, 0, 0, 64'h0, 4'b0000, 0, K_BCOND, 4'hB, 64'h100);
        stepClock();
        checkOutput("blt_taken", {63'b0, bus.br_taken}, 64'h1);
        checkOutput("blt_flags", {60'b0, bus.flags},    64'h8);

        // B.GE with the same flags
        applyStimulus(1, 0, 0, 64'h0, 4'b0000, 0, K_BCOND, 4'hA, 64'h100);
        stepClock();
        checkOutput("bge_taken", {63'b0, bus.br_taken}, 64'h0);

        // SUBS N=0 Z=0 C=1 V=0
        applyStimulus(1, 0, 0, 64'h5, 4'b0010, 1, K_NONE, 4'h0, 64'h0);
        stepClock();
        checkOutput("subs2_flags", {60'b0, bus.flags}, 64'h2);

        applyStimulus(1, 0, 0, 64'h0, 4'b0000, 0, K_BCOND, 4'h8, 64'h200);
        stepClock();
        checkOutput("bhi_taken", {63'b0, bus.br_taken}, 64'h1);

        applyStimulus(1, 0, 0, 64'h0, 4'b0000, 0, K_BCOND, 4'h9, 64'h200);
        stepClock();
        checkOutput("bls_taken", {63'b0, bus.br_taken}, 64'h0);

        applyStimulus(1, 0, 0, 64'h0, 4'b0000, 0, K_BCOND, 4'h0, 64'h200);
        stepClock();
        checkOutput("beq_taken", {63'b0, bus.br_taken}, 64'h0);

        applyStimulus(1, 0, 0, 64'h55, 4'b0000, 0, K_BCOND, 4'hE, 64'h300);
        stepClock();
        checkOutput("bal_taken",  {63'b0, bus.br_taken}, 64'h1);
        checkOutput("bal_result", bus.out_result,        64'h55);

        // ADDS result=0 held by stall for three cycles
        applyStimulus(1, 1, 0, 64'h0, 4'b0100, 1, K_NONE, 4'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("stall_flags",  {60'b0, bus.flags}, 64'h2);
            checkOutput("stall_result", bus.out_result,     64'h55);
            checkOutput("stall_pc",     bus.br_pc,          64'h300);
        end
        bus.stall = 1'b0;
        stepClock();
        checkOutput("unstall_flags",  {60'b0, bus.flags}, 64'h4);
        checkOutput("unstall_result", bus.out_result,     64'h0);

        // Flushed ADDS + B changes nothing
        applyStimulus(1, 0, 1, 64'h7, 4'b1011, 1, K_B, 4'h0, 64'h400);
        stepClock();
        checkOutput("flush_flags", {60'b0, bus.flags},     64'h4);
        checkOutput("flush_valid", {63'b0, bus.out_valid}, 64'h0);
        checkOutput("flush_taken", {63'b0, bus.br_taken},  64'h0);

        // Live B, then flush together with stall
        applyStimulus(1, 0, 0, 64'h9, 4'b0000, 0, K_B, 4'h0, 64'h500);
        stepClock();
        checkOutput("b_valid", {63'b0, bus.out_valid}, 64'h1);
        checkOutput("b_taken", {63'b0, bus.br_taken},  64'h1);
        applyStimulus(1, 1, 1, 64'h7, 4'b1011, 1, K_B, 4'h0, 64'h600);
        stepClock();
        checkOutput("fs_valid", {63'b0, bus.out_valid}, 64'h0);
        checkOutput("fs_taken", {63'b0, bus.br_taken},  64'h0);
        checkOutput("fs_flags", {60'b0, bus.flags},     64'h4);

        // Invalid slot with set_flags and is_b
        applyStimulus(1, 0, 0, 64'h9, 4'b0000, 0, K_B, 4'h0, 64'h500);
        stepClock();
        applyStimulus(0, 0, 0, 64'h3, 4'b1011, 1, K_B, 4'h0, 64'h700);
        stepClock();
        checkOutput("inv_flags", {60'b0, bus.flags},     64'h4);
        checkOutput("inv_valid", {63'b0, bus.out_valid}, 64'h0);
        checkOutput("inv_taken", {63'b0, bus.br_taken},  64'h0);

        // Back-to-back flag setters
        applyStimulus(1, 0, 0, 64'h11, 4'b1001, 1, K_NONE, 4'h0, 64'h0);
        stepClock();
        checkOutput("b2b1_flags", {60'b0, bus.flags}, 64'h9);
        applyStimulus(1, 0, 0, 64'h0, 4'b0110, 1, K_NONE, 4'h0, 64'h0);
        stepClock();
        checkOutput("b2b2_flags", {60'b0, bus.flags}, 64'h6);

        // All flags set plus a taken B, then asynchronous reset between edges
        applyStimulus(1, 0, 0, 64'h1234, 4'b1111, 1, K_B, 4'h0, 64'h99);
        stepClock();
        checkOutput("pre_rst_flags", {60'b0, bus.flags},    64'hF);
        checkOutput("pre_rst_taken", {63'b0, bus.br_taken}, 64'h1);
        checkOutput("pre_rst_pc",    bus.br_pc,             64'h99);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_flags",  {60'b0, bus.flags},     64'h0);
        checkOutput("async_valid",  {63'b0, bus.out_valid}, 64'h0);
        checkOutput("async_taken",  {63'b0, bus.br_taken},  64'h0);
        checkOutput("async_result", bus.out_result,         64'h0);
        checkOutput("async_pc",     bus.br_pc,              64'h0);

        // First live instruction after reset behaves normally
        applyStimulus(1, 0, 0, 64'h0, 4'b0100, 0, K_CBZ, 4'h0, 64'h40);
        @(negedge clk);
        reset = 1'b1;
        stepClock();
        checkOutput("post_valid", {63'b0, bus.out_valid}, 64'h1);
        checkOutput("post_taken", {63'b0, bus.br_taken},  64'h1);
        checkOutput("post_pc",    bus.br_pc,              64'h40);
        checkOutput("post_flags", {60'b0, bus.flags},     64'h0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule

// File: doc/branch_flag_stage.md
# branch_flag_stage

Execute-to-memory boundary stage of the 64-bit pipelined CPU. Consumes the ALU result and the zero-detect output plus the ALU's N/C/V outputs. Holds the architectural NZCV flag register and resolves CBZ/CBNZ/B.cond/B. Registers the result, flags and branch decision for the memory stage with stall and flush control.

## Interface
Parameters:
- `WIDTH`, 64, datapath width of result and branch target.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- `in_valid`  in  1  EX stage holds a live instruction.
- `stall`  in  1  hold all registered state this cycle.
- `flush`  in  1  kill the EX instruction; wins over `stall`.
- `alu_result`  in  WIDTH  ALU output.
- `alu_zero`  in  1  zero-detect of `alu_result` (1 when result is all zeros).
- `alu_neg`, `alu_carry`, `alu_ovf`  in  1 each  ALU N, C, V.
- `set_flags`  in  1  instruction is ADDS/SUBS/ANDS.
- `is_b`, `is_cbz`, `is_cbnz`, `is_bcond`  in  1 each  branch kind (at most one set).
- `cond`  in  4  B.cond code.
- `br_target`  in  WIDTH  computed branch target.
- `out_valid`  out  1  registered valid to MEM.
- `out_result`  out  WIDTH  registered `alu_result`.
- `flags`  out  4  architectural {N,Z,C,V}.
- `br_taken`  out  1  registered taken decision, qualified by `out_valid`.
- `br_pc`  out  WIDTH  registered `br_target`.

## Operation
- Flag register: loads {alu_neg, alu_zero, alu_carry, alu_ovf} when `in_valid & set_flags & ~stall & ~flush`; otherwise holds.
- Branch decision (combinational, then registered):
  - `is_b`: taken.
  - `is_cbz`: taken = `alu_zero`.
  - `is_cbnz`: taken = `~alu_zero`.
  - `is_bcond`: taken = cond_eval(`flags` register, `cond`).
  - No branch kind set: not taken.
- cond_eval uses the currently registered flags, not this cycle's ALU flags. A flag-setting instruction and a B.cond cannot be the same instruction. A B.cond one cycle after ADDS sees the updated flags.
- Codes:
  - 0 EQ Z
  - 1 NE ~Z
  - 2 HS C
  - 3 LO ~C
  - 4 MI N
  - 5 PL ~N
  - 6 VS V
  - 7 VC ~V
  - 8 HI C&~Z
  - 9 LS ~C|Z
  - A GE N==V
  - B LT N!=V
  - C GT ~Z&(N==V)
  - D LE Z|(N!=V)
  - E, F always.
- Pipeline register update priority, highest first:
  - `flush`: out_valid←0, br_taken←0; `out_result` and `br_pc` don't-care; flags hold.
  - `stall`: all registers hold.
  - Otherwise: out_valid←in_valid; out_result←alu_result; br_pc←br_target; br_taken←in_valid & decision.
- Invalid input (`in_valid`=0) never changes flags and never produces `br_taken`=1.

## Timing
- Reset values: out_valid=0, out_result=0, flags=4'b0000, br_taken=0, br_pc=0.
- Latency: 1 cycle from EX inputs to all outputs. Flags are visible on `flags` the cycle after the setting instruction.
- Stall: outputs are stable for every stalled cycle. Inputs in a stalled cycle are ignored, and the EX stage re-presents them afterwards.
- Simultaneous `flush` and `stall`: flush behaviour applies.
- Reset asserted mid-stall or mid-branch: all outputs go to their reset values asynchronously. After deassertion, the first edge with `in_valid` behaves normally.
- Back-to-back flag setters: each updates flags on its own edge; last writer wins.

## Test plan
- Reset mid-operation: flags=4'b1111 with reset pulled low between edges -> flags=0, out_valid=0, br_taken=0 immediately, without waiting for a clock.
- CBZ/CBNZ with result=0, alu_zero=1, is_cbz=1, br_target=0x40 -> next cycle br_taken=1, br_pc=0x40. Same inputs with is_cbnz -> br_taken=0. Result 0x1, alu_zero=0, is_cbnz -> br_taken=1.
- SUBS then B.cond:
  - SUBS with N=1, Z=0, C=0, V=0 then B.LT (cond=B) next cycle -> flags=4'b1000, br_taken=1.
  - B.GE (cond=A) with the same flags -> br_taken=0.
  - B.HI after flags Z=0, C=1 -> br_taken=1.
- Stall hold: ADDS result=0 (Z=1) with stall=1 -> flags unchanged and out_result unchanged over 3 stalled cycles. Release the stall -> flags Z=1 and out_result=0 one cycle later.
- Flush kill: ADDS with flush=1 and is_b=1 -> flags unchanged, out_valid=0, br_taken=0. flush=1 and stall=1 together -> out_valid=0.
- Invalid slot: in_valid=0, set_flags=1, is_b=1 -> flags unchanged, out_valid=0, br_taken=0.
